// File: rtl/hazard_pkg.sv
// Shared types and constants for the merged hazard/forwarding scoreboard.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_t;

  localparam int DEF_REG_AW  = 5;
  localparam int DEF_MUL_LAT = 4;
  localparam int DEF_DIV_LAT = 32;
  localparam int DEF_CNT_W   = 16;

  // Register 0 is hard-wired to zero, so it never produces a hazard.
  localparam int REG_ZERO = 0;

  // The MEM result is younger than the WB result, so it wins when both match.
  function automatic fwd_sel_t fwd_pick(input logic mem_hit, input logic wb_hit);
    if (mem_hit)     return FWD_MEM;
    else if (wb_hit) return FWD_WB;
    else             return FWD_REG;
  endfunction

endpackage

// File: rtl/mdu_busy_counter.sv
// Tracks an in-flight multiply/divide as a down-counter loaded with the op latency.
module mdu_busy_counter
  import hazard_pkg::*;
#(
  parameter int MUL_LAT = DEF_MUL_LAT,
  parameter int DIV_LAT = DEF_DIV_LAT
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic is_div,
  output logic busy,
  output logic done,
  output logic err
);

  localparam int MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  logic [CW-1:0] r_count;
  logic          r_err;
  logic          w_busy;

  assign w_busy = (r_count != '0);
  assign busy   = w_busy;
  assign done   = (r_count == CW'(1));
  assign err    = r_err;

  // Load on an accepted start, count down while busy; a start while busy only raises the sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      if (start && !w_busy) begin
        r_count <= is_div ? CW'(DIV_LAT) : CW'(MUL_LAT);
      end else if (w_busy) begin
        r_count <= r_count - CW'(1);
      end
      if (start && w_busy) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Merged hazard detection, EX operand forwarding, MDU tracking and stall-cycle statistics.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW  = DEF_REG_AW,
  parameter int MUL_LAT = DEF_MUL_LAT,
  parameter int DIV_LAT = DEF_DIV_LAT,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              id_reads_hilo,
  input  logic              id_is_mdu,
  input  logic              id_branch_taken,
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              ex_mem_read,
  input  logic              ex_mdu_start,
  input  logic              ex_mdu_div,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              mem_reg_write,
  input  logic              wb_reg_write,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              control_sel,
  output logic              if_flush,
  output logic [1:0]        a_sel,
  output logic [1:0]        b_sel,
  output logic              mdu_busy,
  output logic              mdu_done,
  output logic              mdu_err,
  output logic [CNT_W-1:0]  stall_count
);

  localparam logic [REG_AW-1:0] ZERO_REG = REG_AW'(REG_ZERO);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  logic             w_mem_wr;
  logic             w_wb_wr;
  logic             w_load_use;
  logic             w_hilo_user;
  logic             w_mdu_hz;
  logic             w_mdu_start_hz;
  logic             w_stall;
  logic             w_mdu_busy;
  logic [CNT_W-1:0] r_stall_count;

  mdu_busy_counter #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) u_mdu (
    .clk    (clk),
    .rst    (rst),
    .start  (ex_mdu_start),
    .is_div (ex_mdu_div),
    .busy   (w_mdu_busy),
    .done   (mdu_done),
    .err    (mdu_err)
  );

  assign mdu_busy = w_mdu_busy;

  // Forwarding: only writers to a non-zero register can supply a bypass value.
  assign w_mem_wr = mem_reg_write && (mem_rd != ZERO_REG);
  assign w_wb_wr  = wb_reg_write  && (wb_rd  != ZERO_REG);
  assign a_sel    = fwd_pick(w_mem_wr && (mem_rd == ex_rs), w_wb_wr && (wb_rd == ex_rs));
  assign b_sel    = fwd_pick(w_mem_wr && (mem_rd == ex_rt), w_wb_wr && (wb_rd == ex_rt));

  // A load in EX cannot be bypassed to ID's consumer in time, so ID must wait one cycle.
  assign w_load_use = ex_mem_read && (ex_rt != ZERO_REG) &&
                      ((id_uses_rs && (ex_rt == id_rs)) || (id_uses_rt && (ex_rt == id_rt)));

  // The start term covers the cycle before busy rises, when the counter has not loaded yet.
  assign w_hilo_user    = id_reads_hilo || id_is_mdu;
  assign w_mdu_hz       = w_mdu_busy   && w_hilo_user;
  assign w_mdu_start_hz = ex_mdu_start && w_hilo_user;
  assign w_stall        = w_load_use || w_mdu_hz || w_mdu_start_hz;

  assign pc_write    = !w_stall;
  assign ifid_write  = !w_stall;
  assign control_sel = w_stall;
  // A stalled branch keeps its fetch; it is resolved again once the stall clears.
  assign if_flush    = id_branch_taken && !w_stall;

  assign stall_count = r_stall_count;

  // Count cycles with the PC held, saturating instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_count <= '0;
    end else if (w_stall && (r_stall_count != CNT_MAX)) begin
      r_stall_count <= r_stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench: directed scenarios plus random stimulus against a timestamp-based model.
module tb_hazard_scoreboard;

  localparam int AW   = 5;
  localparam int MLAT = 4;
  localparam int DLAT = 32;

  logic          clk;
  logic          rst;
  logic [AW-1:0] id_rs, id_rt, ex_rs, ex_rt, mem_rd, wb_rd;
  logic          id_uses_rs, id_uses_rt, id_reads_hilo, id_is_mdu, id_branch_taken;
  logic          ex_mem_read, ex_mdu_start, ex_mdu_div, mem_reg_write, wb_reg_write;

  logic          pc_write, ifid_write, control_sel, if_flush, mdu_busy, mdu_done, mdu_err;
  logic [1:0]    a_sel, b_sel;
  logic [15:0]   stall_count;

  logic          s_pc_write, s_ifid_write, s_control_sel, s_if_flush, s_busy, s_done, s_err;
  logic [1:0]    s_a_sel, s_b_sel;
  logic [3:0]    s_stall_count;

  int n_total = 0;
  int n_bad   = 0;

  hazard_scoreboard #(.REG_AW(AW), .MUL_LAT(MLAT), .DIV_LAT(DLAT), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt), .id_reads_hilo(id_reads_hilo), .id_is_mdu(id_is_mdu),
    .id_branch_taken(id_branch_taken), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_mem_read(ex_mem_read), .ex_mdu_start(ex_mdu_start), .ex_mdu_div(ex_mdu_div),
    .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
    .pc_write(pc_write), .ifid_write(ifid_write), .control_sel(control_sel),
    .if_flush(if_flush), .a_sel(a_sel), .b_sel(b_sel), .mdu_busy(mdu_busy),
    .mdu_done(mdu_done), .mdu_err(mdu_err), .stall_count(stall_count)
  );

  hazard_scoreboard #(.REG_AW(AW), .MUL_LAT(MLAT), .DIV_LAT(DLAT), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt), .id_reads_hilo(id_reads_hilo), .id_is_mdu(id_is_mdu),
    .id_branch_taken(id_branch_taken), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_mem_read(ex_mem_read), .ex_mdu_start(ex_mdu_start), .ex_mdu_div(ex_mdu_div),
    .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
    .pc_write(s_pc_write), .ifid_write(s_ifid_write), .control_sel(s_control_sel),
    .if_flush(s_if_flush), .a_sel(s_a_sel), .b_sel(s_b_sel), .mdu_busy(s_busy),
    .mdu_done(s_done), .mdu_err(s_err), .stall_count(s_stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_idle();
    id_rs = '0; id_rt = '0; ex_rs = '0; ex_rt = '0; mem_rd = '0; wb_rd = '0;
    id_uses_rs = 0; id_uses_rt = 0; id_reads_hilo = 0; id_is_mdu = 0; id_branch_taken = 0;
    ex_mem_read = 0; ex_mdu_start = 0; ex_mdu_div = 0; mem_reg_write = 0; wb_reg_write = 0;
  endtask

  // Leaves the caller at a falling edge with rst released and the DUT freshly reset.
  task automatic do_reset();
    @(negedge clk);
    set_idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [1:0] model_fwd(input logic [AW-1:0] src,
                                           input logic [AW-1:0] mrd, input logic mw,
                                           input logic [AW-1:0] wrd, input logic ww);
    if (mw && mrd != 0 && mrd == src) return 2'd1;
    if (ww && wrd != 0 && wrd == src) return 2'd2;
    return 2'd0;
  endfunction

  task automatic test_reset();
    do_reset();
    #1;
    n_total++;
    if ({pc_write, ifid_write, control_sel, if_flush, a_sel, b_sel} !== 8'b1100_0000) begin
      n_bad++;
      $display("FAIL reset_comb got=%b exp=%b", {pc_write, ifid_write, control_sel, if_flush, a_sel, b_sel}, 8'b1100_0000);
    end
    n_total++;
    if ({mdu_busy, mdu_done, mdu_err, stall_count} !== 19'd0) begin
      n_bad++;
      $display("FAIL reset_state got busy=%b done=%b err=%b cnt=%0d exp all zero", mdu_busy, mdu_done, mdu_err, stall_count);
    end
  endtask

  task automatic test_forwarding();
    @(negedge clk);
    set_idle();
    mem_rd = 3; wb_rd = 3; mem_reg_write = 1; wb_reg_write = 1; ex_rs = 3;
    #1;
    n_total++;
    if (a_sel !== 2'd1) begin n_bad++; $display("FAIL fwd_mem_prio got=%0d exp=1", a_sel); end
    mem_reg_write = 0;
    #1;
    n_total++;
    if (a_sel !== 2'd2) begin n_bad++; $display("FAIL fwd_wb got=%0d exp=2", a_sel); end
    mem_reg_write = 1; mem_rd = 0; ex_rt = 0; wb_rd = 0;
    #1;
    n_total++;
    if (b_sel !== 2'd0) begin n_bad++; $display("FAIL fwd_r0 got=%0d exp=0", b_sel); end
    mem_rd = 7; ex_rt = 7; ex_rs = 9;
    #1;
    n_total++;
    if ({a_sel, b_sel} !== 4'b0001) begin n_bad++; $display("FAIL fwd_b_mem got a=%0d b=%0d exp a=0 b=1", a_sel, b_sel); end
  endtask

  task automatic test_load_use();
    do_reset();
    ex_mem_read = 1; ex_rt = 5; id_rs = 5; id_uses_rs = 1;
    #1;
    n_total++;
    if ({pc_write, ifid_write, control_sel} !== 3'b001) begin
      n_bad++; $display("FAIL load_use_stall got=%b exp=001", {pc_write, ifid_write, control_sel});
    end
    @(negedge clk);
    ex_mem_read = 0;
    #1;
    n_total++;
    if ({pc_write, control_sel, stall_count} !== {2'b10, 16'd1}) begin
      n_bad++; $display("FAIL load_use_release got pc=%b ctl=%b cnt=%0d exp pc=1 ctl=0 cnt=1", pc_write, control_sel, stall_count);
    end
    ex_mem_read = 1; id_uses_rs = 0;
    #1;
    n_total++;
    if ({pc_write, control_sel} !== 2'b10) begin
      n_bad++; $display("FAIL load_use_unused got pc=%b ctl=%b exp pc=1 ctl=0", pc_write, control_sel);
    end
  endtask

  task automatic test_mul();
    do_reset();
    ex_mdu_start = 1; ex_mdu_div = 0; id_reads_hilo = 1;
    #1;
    n_total++;
    if ({pc_write, mdu_busy} !== 2'b00) begin
      n_bad++; $display("FAIL mul_start got pc=%b busy=%b exp 0 0", pc_write, mdu_busy);
    end
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      ex_mdu_start = 0;
      #1;
      n_total++;
      if ({mdu_busy, mdu_done, pc_write} !== {(k <= MLAT), (k == MLAT), (k > MLAT)}) begin
        n_bad++;
        $display("FAIL mul_cycle%0d got busy=%b done=%b pc=%b exp %b %b %b", k, mdu_busy, mdu_done, pc_write,
                 (k <= MLAT), (k == MLAT), (k > MLAT));
      end
    end
    n_total++;
    if (stall_count !== 16'd5) begin n_bad++; $display("FAIL mul_stall_count got=%0d exp=5", stall_count); end
  endtask

  task automatic test_div_reset_err();
    do_reset();
    ex_mdu_start = 1; ex_mdu_div = 1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      ex_mdu_start = 0;
      if (k == 10) rst = 1;
      #1;
      n_total++;
      if ({mdu_busy, mdu_done} !== 2'b10) begin
        n_bad++; $display("FAIL div_cycle%0d got busy=%b done=%b exp 1 0", k, mdu_busy, mdu_done);
      end
    end
    @(negedge clk);
    rst = 0;
    #1;
    n_total++;
    if ({mdu_busy, mdu_done} !== 2'b00) begin
      n_bad++; $display("FAIL div_abort got busy=%b done=%b exp 0 0", mdu_busy, mdu_done);
    end
    ex_mdu_start = 1; ex_mdu_div = 0;
    @(negedge clk);
    ex_mdu_start = 1;
    #1;
    n_total++;
    if ({mdu_busy, mdu_err} !== 2'b10) begin
      n_bad++; $display("FAIL err_before got busy=%b err=%b exp 1 0", mdu_busy, mdu_err);
    end
    for (int k = 2; k <= 8; k++) begin
      @(negedge clk);
      ex_mdu_start = 0;
      #1;
      n_total++;
      if ({mdu_err, mdu_busy} !== {1'b1, (k <= MLAT)}) begin
        n_bad++; $display("FAIL err_sticky%0d got err=%b busy=%b exp 1 %b", k, mdu_err, mdu_busy, (k <= MLAT));
      end
    end
    do_reset();
    #1;
    n_total++;
    if (mdu_err !== 1'b0) begin n_bad++; $display("FAIL err_clear got=%b exp=0", mdu_err); end
  endtask

  task automatic test_branch();
    do_reset();
    ex_mem_read = 1; ex_rt = 5; id_rs = 5; id_uses_rs = 1; id_branch_taken = 1;
    #1;
    n_total++;
    if ({if_flush, pc_write} !== 2'b00) begin
      n_bad++; $display("FAIL branch_stalled got flush=%b pc=%b exp 0 0", if_flush, pc_write);
    end
    @(negedge clk);
    ex_mem_read = 0;
    #1;
    n_total++;
    if ({if_flush, pc_write} !== 2'b11) begin
      n_bad++; $display("FAIL branch_free got flush=%b pc=%b exp 1 1", if_flush, pc_write);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    ex_mem_read = 1; ex_rt = 6; id_rt = 6; id_uses_rt = 1;
    repeat (20) @(negedge clk);
    set_idle();
    #1;
    n_total++;
    if (s_stall_count !== 4'd15) begin n_bad++; $display("FAIL sat_cnt4 got=%0d exp=15", s_stall_count); end
    n_total++;
    if (stall_count !== 16'd20) begin n_bad++; $display("FAIL sat_cnt16 got=%0d exp=20", stall_count); end
  endtask

  // Model keeps the MDU as "start cycle + latency" timestamps rather than a counter.
  task automatic test_random();
    int m_start, m_lat, m_cnt16, m_cnt4;
    bit m_err, m_busy, m_done, m_stall, lu;
    logic [10:0] exp_v, got_v;
    do_reset();
    m_start = -1000; m_lat = 0; m_cnt16 = 0; m_cnt4 = 0; m_err = 0;
    for (int c = 0; c < 600; c++) begin
      id_rs = AW'($urandom_range(0, 3)); id_rt = AW'($urandom_range(0, 3));
      ex_rs = AW'($urandom_range(0, 3)); ex_rt = AW'($urandom_range(0, 3));
      mem_rd = AW'($urandom_range(0, 3)); wb_rd = AW'($urandom_range(0, 3));
      id_uses_rs = 1'($urandom); id_uses_rt = 1'($urandom);
      id_reads_hilo = ($urandom_range(0, 3) == 0); id_is_mdu = ($urandom_range(0, 5) == 0);
      id_branch_taken = 1'($urandom); ex_mem_read = ($urandom_range(0, 2) == 0);
      ex_mdu_start = ($urandom_range(0, 7) == 0); ex_mdu_div = ($urandom_range(0, 5) == 0);
      mem_reg_write = 1'($urandom); wb_reg_write = 1'($urandom);
      rst = ($urandom_range(0, 99) == 0);
      #1;
      m_busy = (c > m_start) && (c <= m_start + m_lat);
      m_done = m_busy && (c == m_start + m_lat);
      lu = ex_mem_read && ex_rt != 0 &&
           ((id_uses_rs && ex_rt == id_rs) || (id_uses_rt && ex_rt == id_rt));
      m_stall = lu || ((m_busy || ex_mdu_start) && (id_reads_hilo || id_is_mdu));
      exp_v = {!m_stall, !m_stall, m_stall, id_branch_taken && !m_stall,
               model_fwd(ex_rs, mem_rd, mem_reg_write, wb_rd, wb_reg_write),
               model_fwd(ex_rt, mem_rd, mem_reg_write, wb_rd, wb_reg_write),
               m_busy, m_done, m_err};
      got_v = {pc_write, ifid_write, control_sel, if_flush, a_sel, b_sel, mdu_busy, mdu_done, mdu_err};
      n_total++;
      if (got_v !== exp_v) begin
        n_bad++; $display("FAIL rand_outputs cycle=%0d got=%b exp=%b", c, got_v, exp_v);
      end
      n_total++;
      if (stall_count !== 16'(m_cnt16) || s_stall_count !== 4'(m_cnt4)) begin
        n_bad++; $display("FAIL rand_count cycle=%0d got=%0d/%0d exp=%0d/%0d", c, stall_count, s_stall_count, m_cnt16, m_cnt4);
      end
      if (rst) begin
        m_start = -1000; m_err = 0; m_cnt16 = 0; m_cnt4 = 0;
      end else begin
        if (ex_mdu_start) begin
          if (m_busy) m_err = 1;
          else begin m_start = c; m_lat = ex_mdu_div ? DLAT : MLAT; end
        end
        if (m_stall) begin
          if (m_cnt16 < 65535) m_cnt16++;
          if (m_cnt4 < 15) m_cnt4++;
        end
      end
      @(negedge clk);
    end
    rst = 0;
  endtask

  initial begin
    rst = 1'b1;
    set_idle();
    test_reset();
    test_forwarding();
    test_load_use();
    test_mul();
    test_div_reset_err();
    test_branch();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the pipeline's separate hazard and forwarding units; merges them into one block.
- Adds multi-cycle multiply/divide (MDU) busy tracking, branch-flush arbitration and a saturating stall-cycle counter.
- Sits beside the datapath and controller in the 5-stage pipeline top.
- Drives PC/IF-ID write enables, bubble insertion, IF flush and EX operand forwarding selects.

Parameters:
- REG_AW, 5, register address width (register 0 hard-wired zero).
- MUL_LAT, 4, multiply latency in cycles (>=2).
- DIV_LAT, 32, divide latency in cycles (>=2).
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- id_rs, id_rt  in  REG_AW  source registers of the instruction in ID
- id_uses_rs, id_uses_rt  in  1  ID instruction actually reads rs / rt
- id_reads_hilo  in  1  ID instruction is mfhi/mflo
- id_is_mdu  in  1  ID instruction is mult/div
- id_branch_taken  in  1  branch resolved taken in ID
- ex_rs, ex_rt  in  REG_AW  EX-stage sources
- ex_mem_read  in  1  EX instruction is a load
- ex_mdu_start  in  1  MDU op enters EX this cycle
- ex_mdu_div  in  1  1=divide, 0=multiply (valid with ex_mdu_start)
- mem_rd, wb_rd  in  REG_AW  destinations in MEM / WB
- mem_reg_write, wb_reg_write  in  1  MEM / WB write the register file
- pc_write, ifid_write  out  1  enables; 0 = hold
- control_sel  out  1  1 = zero ID control signals (bubble into ID/EX)
- if_flush  out  1  squash the IF/ID register
- a_sel, b_sel  out  2  EX operand select: 0=regfile, 1=MEM, 2=WB
- mdu_busy  out  1  MDU operation in flight
- mdu_done  out  1  single-cycle pulse in the last busy cycle
- mdu_err  out  1  sticky: start received while busy
- stall_count  out  CNT_W  saturating count of stalled cycles

Behaviour:
- Clocking: one clock; reset is synchronous and active-high.
- Reset: mdu counter=0, mdu_busy=0, mdu_done=0, mdu_err=0, stall_count=0. Combinational outputs then reflect the inputs, and with idle inputs give pc_write=1, ifid_write=1, control_sel=0, if_flush=0, a_sel=b_sel=0.
- Reset mid-MDU-operation: aborts the operation; no mdu_done pulse.

Forwarding (combinational, zero latency), evaluated separately for a_sel (ex_rs) and b_sel (ex_rt):
- Select 1 if mem_reg_write and mem_rd!=0 and mem_rd==src.
- Otherwise select 2 if wb_reg_write and wb_rd!=0 and wb_rd==src.
- Otherwise select 0. MEM has priority over WB.

Stall conditions (combinational) — any one of:
- load_use: ex_mem_read and ex_rt!=0 and ((id_uses_rs and ex_rt==id_rs) or (id_uses_rt and ex_rt==id_rt)).
- mdu_hz: mdu_busy and (id_reads_hilo or id_is_mdu).
- mdu_start_hz: ex_mdu_start and (id_reads_hilo or id_is_mdu). This covers the cycle before busy rises.

Stall response:
- pc_write=0, ifid_write=0, control_sel=1.
- if_flush = id_branch_taken and not stall. Stall wins; the branch is re-resolved once the stall clears.

MDU counter:
- On ex_mdu_start while not busy: load (ex_mdu_div ? DIV_LAT : MUL_LAT). mdu_busy = (count!=0).
- Decrement each cycle while nonzero. mdu_done=1 when count==1. Busy lasts exactly LAT cycles after the start edge.
- ex_mdu_start while busy: ignored (counter unaffected) and mdu_err set; cleared only by rst.

Stall counter:
- stall_count += 1 on each cycle with pc_write==0.
- Holds at 2^CNT_W-1 (no wrap).

Decomposition:
- Package hazard_pkg holds:
  - fwd_sel_t enum: FWD_REG=2'd0, FWD_MEM=2'd1, FWD_WB=2'd2
  - default latency constants
  - a REG_ZERO constant
- Sub-module mdu_busy_counter (clk, rst, start, is_div, busy, done, err) is parametrised by MUL_LAT and DIV_LAT.
- The top contains the forwarding/stall logic and the stall counter.

Test Plan:
- Forwarding: mem_rd=3 and wb_rd=3, both writes, ex_rs=3 -> a_sel=1. Drop mem_reg_write -> a_sel=2. Set ex_rt=0 with mem_rd=0 -> b_sel=0.
- Load-use: ex_mem_read=1, ex_rt=5, id_rs=5, id_uses_rs=1 -> pc_write=0, ifid_write=0, control_sel=1 for one cycle. Same case with id_uses_rs=0 -> no stall.
- MUL: ex_mdu_start, ex_mdu_div=0 -> mdu_busy high 4 cycles, mdu_done on the 4th. With id_reads_hilo held, the stall lasts 5 cycles total and stall_count=5.
- DIV: start then rst on cycle 10 -> mdu_busy=0 next cycle, no mdu_done. A second start while busy -> mdu_err=1 and it stays set.
- Branch vs stall: id_branch_taken=1 during a load_use stall -> if_flush=0. Next cycle, with no stall -> if_flush=1.
- Saturation: CNT_W=4, hold a stall for 20 cycles -> stall_count=15.
